// File: rtl/tmr_pkg.sv
// Shared constants for the TMR vote sequencer: mode encoding, channel indices,
// counter width and the fault-mask to mode decode.
package tmr_pkg;

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] MODE_TMR    = 2'd0;
  localparam logic [1:0] MODE_DMR    = 2'd1;
  localparam logic [1:0] MODE_FAILED = 2'd2;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;

  function automatic logic [1:0] mode_of(input logic [2:0] f);
    logic [1:0] n;
    n = {1'b0, f[0]} + {1'b0, f[1]} + {1'b0, f[2]};
    if (n == 2'd0) begin
      return MODE_TMR;
    end else if (n == 2'd1) begin
      return MODE_DMR;
    end else begin
      return MODE_FAILED;
    end
  endfunction

endpackage

// File: rtl/tmr_vote3.sv
// Bitwise 2-of-3 majority of three W-bit words.
module tmr_vote3 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o
);

  assign y_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/tmr_vote_sequencer.sv
// Handshaked TMR voter with per-channel disagreement counters that retire
// channels and degrade TMR -> DMR -> FAILED.
module tmr_vote_sequencer
  import tmr_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] y,
  output logic         out_err,
  output logic [2:0]   mismatch,
  output logic [2:0]   fault,
  output logic [1:0]   mode,
  input  logic         fault_clr
);

  localparam logic [CNT_W-1:0] THRESH = CNT_W'(FAULT_THRESH);

  logic [W-1:0]     ch [3];
  logic [W-1:0]     maj;
  logic             accept;

  logic [W-1:0]     vote_y;
  logic             vote_err;
  logic [2:0]       vote_mis;
  logic [1:0]       lo, hi;

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     y_q, y_d;
  logic             err_q, err_d;
  logic [2:0]       mis_q, mis_d;
  logic [2:0]       fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  assign ch[CH_A] = a;
  assign ch[CH_B] = b;
  assign ch[CH_C] = c;

  tmr_vote3 #(
    .W(W)
  ) u_vote (
    .a_i(a),
    .b_i(b),
    .c_i(c),
    .y_o(maj)
  );

  assign mode     = mode_of(fault_q);
  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    vote_y   = maj;
    vote_err = 1'b0;
    vote_mis = '0;
    lo       = CH_A;
    hi       = CH_B;
    if (fault_q[CH_A]) begin
      lo = CH_B;
      hi = CH_C;
    end else if (fault_q[CH_B]) begin
      hi = CH_C;
    end
    case (mode)
      MODE_TMR: begin
        for (int i = 0; i < 3; i++) vote_mis[i] = (ch[i] != maj);
      end
      MODE_DMR: begin
        vote_y       = ch[lo];
        vote_err     = (ch[lo] != ch[hi]);
        vote_mis[hi] = vote_err;
      end
      default: begin
        vote_err = 1'b1;
        if (!fault_q[CH_A])      vote_y = ch[CH_A];
        else if (!fault_q[CH_B]) vote_y = ch[CH_B];
        else if (!fault_q[CH_C]) vote_y = ch[CH_C];
        else                     vote_y = ch[CH_A];
      end
    endcase
  end

  // Counters only move in TMR; a clear on the same edge discards the update.
  always_comb begin
    fault_d = fault_q;
    for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i];
    if (fault_clr) begin
      fault_d = '0;
      for (int i = 0; i < 3; i++) cnt_d[i] = '0;
    end else if (accept && mode == MODE_TMR) begin
      for (int i = 0; i < 3; i++) begin
        if (vote_mis[i]) begin
          if (cnt_q[i] != THRESH) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (cnt_q[i] + CNT_W'(1) == THRESH) fault_d[i] = 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    y_d         = y_q;
    err_d       = err_q;
    mis_d       = mis_q;
    if (accept) begin
      out_valid_d = 1'b1;
      y_d         = vote_y;
      err_d       = vote_err;
      mis_d       = vote_mis;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      y_q         <= '0;
      err_q       <= 1'b0;
      mis_q       <= '0;
      fault_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      y_q         <= y_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      fault_q     <= fault_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign out_err   = err_q;
  assign mismatch  = mis_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_tmr_vote_sequencer.sv
// Directed bench for tmr_vote_sequencer with hand-computed expectations.
module tb_tmr_vote_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       out_err;
  logic [2:0] mismatch;
  logic [2:0] fault;
  logic [1:0] mode;
  logic       fault_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr_vote_sequencer #(
    .W(8),
    .FAULT_THRESH(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c        (c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .out_err  (out_err),
    .mismatch (mismatch),
    .fault    (fault),
    .mode     (mode),
    .fault_clr(fault_clr)
  );

  // Present one triple for one edge, then sample 1 time unit after that edge.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [7:0] vc,
                      input logic clr);
    @(negedge clk);
    a = va; b = vb; c = vc;
    in_valid  = 1'b1;
    fault_clr = clr;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    fault_clr = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    fault_clr = 1'b1;
    @(posedge clk);
    #1;
    fault_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; fault_clr = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 8'h00 || out_err !== 1'b0 || mismatch !== 3'b000 ||
        fault !== 3'b000 || mode !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: ov=%b y=%h err=%b mis=%b fault=%b mode=%0d rdy=%b, want 0 00 0 000 000 0 1",
               out_valid, y, out_err, mismatch, fault, mode, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tmr_agree();
    send(8'h5A, 8'h5A, 8'h5A, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h5A || mismatch !== 3'b000 || out_err !== 1'b0 ||
        mode !== 2'd0) begin
      errors++;
      $display("FAIL tmr_agree: ov=%b y=%h mis=%b err=%b mode=%0d, want 1 5a 000 0 0",
               out_valid, y, mismatch, out_err, mode);
    end
  endtask

  task automatic test_tmr_majority();
    send(8'hF0, 8'hCC, 8'hAA, 1'b0);
    checks++;
    if (y !== 8'hE8 || mismatch !== 3'b111 || out_err !== 1'b0 || fault !== 3'b000) begin
      errors++;
      $display("FAIL tmr_majority: y=%h mis=%b err=%b fault=%b, want e8 111 0 000",
               y, mismatch, out_err, fault);
    end
    send(8'h3C, 8'h3C, 8'h3D, 1'b0);
    checks++;
    if (y !== 8'h3C || mismatch !== 3'b100) begin
      errors++;
      $display("FAIL tmr_single_flip: y=%h mis=%b, want 3c 100", y, mismatch);
    end
  endtask

  task automatic test_dmr_retire();
    send(8'h11, 8'h11, 8'h11, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(8'h11, 8'h11, 8'hEE, 1'b0);
      checks++;
      if (y !== 8'h11 || mismatch !== 3'b100 ||
          fault !== ((i == 3) ? 3'b100 : 3'b000) || mode !== ((i == 3) ? 2'd1 : 2'd0)) begin
        errors++;
        $display("FAIL dmr_retire word %0d: y=%h mis=%b fault=%b mode=%0d", i, y, mismatch,
                 fault, mode);
      end
    end
    send(8'h11, 8'h12, 8'h00, 1'b0);
    checks++;
    if (y !== 8'h11 || out_err !== 1'b1 || mismatch !== 3'b010 || mode !== 2'd1) begin
      errors++;
      $display("FAIL dmr_disagree: y=%h err=%b mis=%b mode=%0d, want 11 1 010 1",
               y, out_err, mismatch, mode);
    end
    send(8'h33, 8'h33, 8'h99, 1'b0);
    checks++;
    if (y !== 8'h33 || out_err !== 1'b0 || mismatch !== 3'b000 || fault !== 3'b100) begin
      errors++;
      $display("FAIL dmr_agree: y=%h err=%b mis=%b fault=%b, want 33 0 000 100",
               y, out_err, mismatch, fault);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    checks++;
    if (fault !== 3'b000 || mode !== 2'd0) begin
      errors++;
      $display("FAIL clear_idle: fault=%b mode=%0d, want 000 0", fault, mode);
    end
    send(8'h21, 8'h21, 8'h21, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    a = 8'h42; b = 8'h42; c = 8'h42;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || y !== 8'h21 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall cycle %0d: rdy=%b y=%h ov=%b, want 0 21 1", i, in_ready, y,
                 out_valid);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL release_ready: rdy=%b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (y !== 8'h42 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first: y=%h ov=%b, want 42 1", y, out_valid);
    end
    @(negedge clk);
    a = 8'h63; b = 8'h63; c = 8'h63;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (y !== 8'h63 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second: y=%h ov=%b, want 63 1", y, out_valid);
    end
  endtask

  task automatic test_double_fault();
    for (int i = 0; i < 4; i++) begin
      send(8'h01, 8'h02, 8'h00, 1'b0);
      checks++;
      if (y !== 8'h00 || mismatch !== 3'b011 ||
          fault !== ((i == 3) ? 3'b011 : 3'b000) || mode !== ((i == 3) ? 2'd2 : 2'd0)) begin
        errors++;
        $display("FAIL double_fault word %0d: y=%h mis=%b fault=%b mode=%0d", i, y, mismatch,
                 fault, mode);
      end
    end
    send(8'h55, 8'h66, 8'h77, 1'b0);
    checks++;
    if (y !== 8'h77 || out_err !== 1'b1 || mismatch !== 3'b000 || mode !== 2'd2) begin
      errors++;
      $display("FAIL failed_vote: y=%h err=%b mis=%b mode=%0d, want 77 1 000 2",
               y, out_err, mismatch, mode);
    end
  endtask

  task automatic test_clear_race();
    pulse_clear();
    for (int i = 0; i < 3; i++) send(8'h11, 8'h11, 8'hEE, 1'b0);
    send(8'h11, 8'h11, 8'hEE, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || y !== 8'h11 || mismatch !== 3'b100 || fault !== 3'b000 ||
        mode !== 2'd0) begin
      errors++;
      $display("FAIL clear_race: ov=%b y=%h mis=%b fault=%b mode=%0d, want 1 11 100 000 0",
               out_valid, y, mismatch, fault, mode);
    end
    for (int i = 0; i < 3; i++) send(8'h11, 8'h11, 8'hEE, 1'b0);
    checks++;
    if (fault !== 3'b000) begin
      errors++;
      $display("FAIL clear_counters: fault=%b, want 000", fault);
    end
  endtask

  task automatic test_reset_midstall();
    send(8'h7E, 8'h7E, 8'h7E, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 8'h00 || fault !== 3'b000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_midstall: ov=%b y=%h fault=%b rdy=%b, want 0 00 000 1",
               out_valid, y, fault, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tmr_agree();
    test_tmr_majority();
    test_dmr_retire();
    test_back_to_back();
    test_double_fault();
    test_clear_race();
    test_reset_midstall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
